rrc_rd_seq: RTL

RRC_RD_SEQ -- requirements
Module: rrc_rd_seq

---
 rtl/rrc_rd_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rrc_rd_seq.sv
// Read sequencer for the RRC flash macro: it accepts one read request at a time,
// sequences CE/AE/XE/YE then READ, and returns data or a timeout flag through a valid/ready response.
module rrc_rd_seq #(
  parameter int unsigned TSETUP = 2,
  parameter int unsigned TMO    = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [10:0]  req_xadr,
  input  logic [4:0]   req_yadr,
  input  logic         req_ifren,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [143:0] rsp_data,
  output logic [1:0]   rsp_cr,
  output logic         rsp_err,
  output logic         rr_ce,
  output logic         rr_ae,
  output logic         rr_xe,
  output logic         rr_ye,
  output logic         rr_read,
  output logic         rr_ifren,
  output logic [10:0]  rr_xadr,
  output logic [4:0]   rr_yadr,
  input  logic [143:0] rr_dout,
  input  logic [1:0]   rr_dout_cr,
  input  logic         rr_rdone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(TSETUP - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TMO - 1);

  state_t         state_r;
  state_t         state_s;
  logic [7:0]     cnt_r;
  logic [7:0]     cnt_s;
  logic [10:0]    xadr_s;
  logic [4:0]     yadr_s;
  logic           ifren_s;
  logic [143:0]   data_s;
  logic [1:0]     cr_s;
  logic           err_s;
  logic           drive_s;
  logic           read_s;

  // Next-state, counter and next values for every registered output.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    xadr_s  = rr_xadr;
    yadr_s  = rr_yadr;
    ifren_s = rr_ifren;
    data_s  = rsp_data;
    cr_s    = rsp_cr;
    err_s   = rsp_err;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_s = SETUP;
          cnt_s   = 8'd0;
          xadr_s  = req_xadr;
          yadr_s  = req_yadr;
          ifren_s = req_ifren;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = READ;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      READ: begin
        // rdone takes priority over an expiring timeout on the same edge
        if (rr_rdone) begin
          state_s = RESP;
          data_s  = rr_dout;
          cr_s    = rr_dout_cr;
          err_s   = 1'b0;
        end else if (cnt_r == TMO_LAST) begin
          state_s = RESP;
          data_s  = 144'd0;
          cr_s    = 2'd0;
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
    drive_s = (state_s == SETUP) || (state_s == READ);
    read_s  = (state_s == READ);
  end

  // State, counter and all outputs registered from their next values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 144'd0;
      rsp_cr    <= 2'd0;
      rsp_err   <= 1'b0;
      rr_ce     <= 1'b0;
      rr_ae     <= 1'b0;
      rr_xe     <= 1'b0;
      rr_ye     <= 1'b0;
      rr_read   <= 1'b0;
      rr_ifren  <= 1'b0;
      rr_xadr   <= 11'd0;
      rr_yadr   <= 5'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      req_ready <= (state_s == IDLE);
      rsp_valid <= (state_s == RESP);
      rsp_data  <= data_s;
      rsp_cr    <= cr_s;
      rsp_err   <= err_s;
      rr_ce     <= drive_s;
      rr_ae     <= drive_s;
      rr_xe     <= drive_s;
      rr_ye     <= drive_s;
      rr_read   <= read_s;
      rr_ifren  <= ifren_s;
      rr_xadr   <= xadr_s;
      rr_yadr   <= yadr_s;
    end
  end

endmodule
